// File: rtl/cpu_mem_pkg.sv
// Shared encodings and word-lane helpers for the CPU load/store path into the data RAM.
package cpu_mem_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned RAM_ADDR_W = 32;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK    = 2'b00,
        ERR_ALIGN = 2'b01,
        ERR_RANGE = 2'b10
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_ISSUE  = 3'd1,
        ST_RD_DATA   = 3'd2,
        ST_RMW_ISSUE = 3'd3,
        ST_RMW_DATA  = 3'd4,
        ST_WR_ISSUE  = 3'd5,
        ST_WR_STAT   = 3'd6,
        ST_RESP      = 3'd7
    } state_e;

    // Illegal size code, or an access that does not sit on its natural boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        return (size == SIZE_X) ||
               ((size == SIZE_H) && lane[0]) ||
               ((size == SIZE_W) && (lane != 2'b00));
    endfunction

    // Bit offset of the addressed lane inside the little-endian word.
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] lane);
        return (size == SIZE_H) ? {lane[1], 4'b0000} : {lane, 3'b000};
    endfunction

    function automatic logic [WORD_W-1:0] extract_lane(input logic [WORD_W-1:0] word,
                                                       input logic [1:0]        size,
                                                       input logic [1:0]        lane,
                                                       input logic              sgn);
        logic [WORD_W-1:0] shifted;
        logic [WORD_W-1:0] result;
        shifted = word >> lane_shift(size, lane);
        case (size)
            SIZE_B:  result = {{(WORD_W-8){sgn & shifted[7]}}, shifted[7:0]};
            SIZE_H:  result = {{(WORD_W-16){sgn & shifted[15]}}, shifted[15:0]};
            default: result = word;
        endcase
        return result;
    endfunction

    function automatic logic [WORD_W-1:0] merge_lane(input logic [WORD_W-1:0] word,
                                                     input logic [WORD_W-1:0] wdata,
                                                     input logic [1:0]        size,
                                                     input logic [1:0]        lane);
        logic [WORD_W-1:0] mask;
        logic [4:0]        sh;
        case (size)
            SIZE_B:  mask = WORD_W'(8'hFF);
            SIZE_H:  mask = WORD_W'(16'hFFFF);
            default: mask = '1;
        endcase
        sh = lane_shift(size, lane);
        return (word & ~(mask << sh)) | ((wdata & mask) << sh);
    endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational lane extract (with sign extension) and store merge shared by the read and RMW paths.
module lane_align
    import cpu_mem_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    input  logic [1:0]        i_size,
    input  logic [1:0]        i_lane,
    input  logic              i_signed,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_load,
    output logic [WORD_W-1:0] o_merged
);

    assign o_load   = extract_lane(i_word, i_size, i_lane, i_signed);
    assign o_merged = merge_lane(i_word, i_wdata, i_size, i_lane);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end: one byte-addressed CPU request at a time, mapped onto word RAM
// accesses with read-modify-write for sub-word stores.
module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic [1:0]            resp_err,
    output logic [RAM_ADDR_W-1:0] ram_r_addr,
    output logic [RAM_ADDR_W-1:0] ram_w_addr,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_w_line,
    input  logic [DATA_W-1:0]     ram_r_line,
    input  logic                  ram_exc
);

    state_e              r_state;
    logic                r_we;
    logic                r_signed;
    logic [1:0]          r_size;
    logic [1:0]          r_lane;
    logic [DATA_W-1:0]   r_wdata;

    logic [DATA_W-1:0]   w_load;
    logic [DATA_W-1:0]   w_merged;
    logic                w_misaligned;
    logic [RAM_ADDR_W-1:0] w_word_addr;

    assign req_ready    = (r_state == ST_IDLE);
    assign w_misaligned = is_misaligned(req_size, req_addr[1:0]);
    assign w_word_addr  = RAM_ADDR_W'(req_addr[ADDR_W-1:2]);

    lane_align u_lane_align (
        .i_word   (ram_r_line),
        .i_size   (r_size),
        .i_lane   (r_lane),
        .i_signed (r_signed),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    // Transaction sequencer; RAM strobes default low so every issue state pulses exactly once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_signed   <= 1'b0;
            r_size     <= 2'b00;
            r_lane     <= 2'b00;
            r_wdata    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= ERR_OK;
            ram_read   <= 1'b0;
            ram_write  <= 1'b0;
            ram_r_addr <= '0;
            ram_w_addr <= '0;
            ram_w_line <= '0;
        end else begin
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_signed   <= req_signed;
                        r_size     <= req_size;
                        r_lane     <= req_addr[1:0];
                        r_wdata    <= req_wdata;
                        ram_r_addr <= w_word_addr;
                        ram_w_addr <= w_word_addr;
                        resp_rdata <= '0;
                        resp_err   <= ERR_OK;
                        if (w_misaligned) begin
                            resp_err   <= ERR_ALIGN;
                            resp_valid <= 1'b1;
                            r_state    <= ST_RESP;
                        end else if (!req_we) begin
                            ram_read <= 1'b1;
                            r_state  <= ST_RD_ISSUE;
                        end else if (req_size == SIZE_W) begin
                            ram_w_line <= req_wdata;
                            ram_write  <= 1'b1;
                            r_state    <= ST_WR_ISSUE;
                        end else begin
                            ram_read <= 1'b1;
                            r_state  <= ST_RMW_ISSUE;
                        end
                    end
                end
                ST_RD_ISSUE:  r_state <= ST_RD_DATA;
                ST_RD_DATA: begin
                    resp_valid <= 1'b1;
                    resp_err   <= ram_exc ? ERR_RANGE : ERR_OK;
                    resp_rdata <= ram_exc ? '0 : w_load;
                    r_state    <= ST_RESP;
                end
                ST_RMW_ISSUE: r_state <= ST_RMW_DATA;
                ST_RMW_DATA: begin
                    if (ram_exc) begin
                        resp_valid <= 1'b1;
                        resp_err   <= ERR_RANGE;
                        r_state    <= ST_RESP;
                    end else begin
                        ram_w_line <= w_merged;
                        ram_write  <= 1'b1;
                        r_state    <= ST_WR_ISSUE;
                    end
                end
                ST_WR_ISSUE:  r_state <= ST_WR_STAT;
                ST_WR_STAT: begin
                    resp_valid <= 1'b1;
                    resp_err   <= ram_exc ? ERR_RANGE : ERR_OK;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-array reference model, 1024-word RAM model,
// directed cases from the test plan followed by randomized traffic.
module tb_mem_access_unit;

    localparam int unsigned RAM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] ram_r_addr;
    logic [31:0] ram_w_addr;
    logic        ram_read;
    logic        ram_write;
    logic [31:0] ram_w_line;
    logic [31:0] ram_r_line = '0;
    logic        ram_exc = 1'b0;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_r_addr (ram_r_addr),
        .ram_w_addr (ram_w_addr),
        .ram_read   (ram_read),
        .ram_write  (ram_write),
        .ram_w_line (ram_w_line),
        .ram_r_line (ram_r_line),
        .ram_exc    (ram_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
        int          nrd;
        int          nwr;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          stall_left = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    bit          active = 1'b0;
    logic [31:0] snap_rdata;
    logic [1:0]  snap_err;

    logic [7:0]  ref_mem [4096];
    logic [31:0] ram_mem [RAM_WORDS];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Emulation of the downstream RAM: registered read data and range flag; bus is junk when idle.
    always @(posedge clk) begin
        if (ram_write && ram_w_addr < RAM_WORDS) ram_mem[ram_w_addr[9:0]] <= ram_w_line;
        if (ram_read)
            ram_r_line <= (ram_r_addr < RAM_WORDS) ? ram_mem[ram_r_addr[9:0]] : $urandom;
        else
            ram_r_line <= $urandom;
        if (ram_read)       ram_exc <= (ram_r_addr >= RAM_WORDS);
        else if (ram_write) ram_exc <= (ram_w_addr >= RAM_WORDS);
        else                ram_exc <= 1'($urandom);
    end

    // Reference behaviour straight from the load/store rules, on a byte-addressed memory.
    function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output exp_t e);
        int          nb;
        logic [31:0] v;
        bit          oor;
        e.rdata = '0; e.err = 2'b00; e.lat = 1; e.nrd = 0; e.nwr = 0; e.acc = 0;
        if (size == 2'b11) begin e.err = 2'b01; return; end
        nb = 1 << size;
        if ((addr % nb) != 0) begin e.err = 2'b01; return; end
        oor = (addr / 4) >= RAM_WORDS;
        if (!we) begin
            e.lat = 3; e.nrd = 1;
            if (oor) e.err = 2'b10;
            else begin
                v = '0;
                for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8 * i));
                if (sgn && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
                e.rdata = v;
            end
        end else if (nb == 4) begin
            e.lat = 3; e.nwr = 1;
            if (oor) e.err = 2'b10;
            else for (int i = 0; i < 4; i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * i));
        end else begin
            e.nrd = 1;
            if (oor) begin e.lat = 3; e.err = 2'b10; end
            else begin
                e.lat = 5; e.nwr = 1;
                for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * i));
            end
        end
    endfunction

    // Monitor: pops an expectation on each new response, then checks it stays frozen while stalled.
    always @(negedge clk) begin
        if (rst) begin
            active = 1'b0; rd_cnt = 0; wr_cnt = 0; resp_ready = 1'b0;
        end else begin
            if (ram_read)  rd_cnt++;
            if (ram_write) wr_cnt++;
            if (resp_valid && !active) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_rdata", resp_rdata, mon_e.rdata);
                    chk("resp_err", 32'(resp_err), 32'(mon_e.err));
                    chk("latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
                    chk("ram_read_pulses", 32'(rd_cnt), 32'(mon_e.nrd));
                    chk("ram_write_pulses", 32'(wr_cnt), 32'(mon_e.nwr));
                end
                snap_rdata = resp_rdata; snap_err = resp_err;
                active = 1'b1; rd_cnt = 0; wr_cnt = 0;
            end else if (active) begin
                chk("stall_valid", 32'(resp_valid), 32'd1);
                chk("stall_rdata", resp_rdata, snap_rdata);
                chk("stall_err", 32'(resp_err), 32'(snap_err));
            end
            if (active) begin
                if (stall_left > 0) begin resp_ready = 1'b0; stall_left--; end
                else resp_ready = (($urandom % 3) != 0);
                if (resp_ready) active = 1'b0;
            end else begin
                resp_ready = 1'($urandom);
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (!req_ready) begin
            if (++t > 100) begin
                chk("req_ready_timeout", 32'(req_ready), 32'd1);
                finish_run();
            end
            @(negedge clk);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
    endtask

    task automatic scramble();
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        wait_ready();
        model(we, size, sgn, addr, wdata, e);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        drive(we, size, sgn, addr, wdata);
        @(negedge clk);
        scramble();
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 || active || resp_valid) begin
            if (++t > 200) begin
                chk("drain_timeout", 32'(exp_q.size()), 32'd0);
                finish_run();
            end
            @(negedge clk);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"},  32'(req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_resp_err"},   32'(resp_err), 32'd0);
        chk({tag, "_ram_read"},   32'(ram_read), 32'd0);
        chk({tag, "_ram_write"},  32'(ram_write), 32'd0);
        chk({tag, "_ram_r_addr"}, ram_r_addr, 32'd0);
        chk({tag, "_ram_w_addr"}, ram_w_addr, 32'd0);
        chk({tag, "_ram_w_line"}, ram_w_line, 32'd0);
    endtask

    initial begin
        #500000;
        chk("watchdog", 32'd0, 32'd1);
        finish_run();
    end

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        logic [1:0]  sz;
        int          bad;
        for (int w = 0; w < int'(RAM_WORDS); w++) begin
            v = (w == 4) ? 32'hDEADBEEF : $urandom;
            ram_mem[w] = v;
            for (int j = 0; j < 4; j++) ref_mem[4*w + j] = 8'(v >> (8 * j));
        end

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b0;

        issue(1'b0, 2'b10, 1'b0, 32'h010, 32'h0);         // 0xDEADBEEF
        issue(1'b0, 2'b00, 1'b1, 32'h013, 32'h0);         // 0xFFFFFFDE
        issue(1'b0, 2'b01, 1'b0, 32'h010, 32'h0);         // 0x0000BEEF
        issue(1'b1, 2'b00, 1'b0, 32'h011, 32'hA5A5A555);
        drain();
        chk("ram_word4_after_byte_store", ram_mem[4], 32'hDEAD55EF);
        issue(1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h001, 32'h0);
        issue(1'b0, 2'b11, 1'b0, 32'h010, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h1000, 32'h12345678);
        issue(1'b1, 2'b00, 1'b0, 32'h1000, 32'h000000AA);
        issue(1'b0, 2'b10, 1'b0, 32'hFFFF_F010, 32'h0);   // word index wraps far past the RAM
        drain();

        stall_left = 4;
        issue(1'b0, 2'b00, 1'b0, 32'h012, 32'h0);
        drain();

        // Sub-word store cut off by reset while in its read-data cycle: no write may follow.
        wait_ready();
        drive(1'b1, 2'b01, 1'b0, 32'h022, 32'h0000CAFE);
        @(negedge clk);
        scramble();
        chk("rmw_issue_read", 32'(ram_read), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("mid_rst");
        rst = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h020, 32'h0);
        drain();

        for (int n = 0; n < 300; n++) begin
            case ($urandom % 10)
                0:       sz = 2'b11;
                1, 2, 3: sz = 2'b00;
                4, 5, 6: sz = 2'b01;
                default: sz = 2'b10;
            endcase
            case ($urandom % 20)
                0:             a = $urandom;
                1, 2, 3:       a = 32'($urandom_range(4096, 8191));
                default:       a = 32'($urandom_range(0, 4095));
            endcase
            if (($urandom % 4) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
            issue(1'($urandom), sz, 1'($urandom), a, $urandom);
        end
        drain();

        bad = 0;
        for (int w = 0; w < int'(RAM_WORDS); w++) begin
            v = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
            if (ram_mem[w] !== v) bad++;
        end
        chk("ram_contents_mismatched_words", 32'(bad), 32'd0);
        finish_run();
    end

endmodule
